// File: rtl/sd_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// sd_cmd_sequencer_if
// Byte-transfer handshake between sd_cmd_sequencer and spi_controller, plus
// the SD chip select that frames each command.
//   cs_n          SD chip select, active low
//   spi_execute   one-cycle start pulse for a byte transfer
//   spi_out_word  byte to transmit, stable from execute until finished
//   spi_in_word   byte received, valid while spi_finished=1
//   spi_finished  one-cycle pulse: byte transfer complete
// Modports: master = sequencer side, slave = spi_controller side.
// ----------------------------------------------------------------------------
interface sd_cmd_sequencer_if;
   logic       cs_n;
   logic       spi_execute;
   logic [7:0] spi_out_word;
   logic [7:0] spi_in_word;
   logic       spi_finished;

   modport master (
      output cs_n,
      output spi_execute,
      output spi_out_word,
      input  spi_in_word,
      input  spi_finished
   );

   modport slave (
      input  cs_n,
      input  spi_execute,
      input  spi_out_word,
      output spi_in_word,
      output spi_finished
   );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// sd_cmd_sequencer
// Issues one SD SPI-mode command frame through spi_controller and collects
// the R1 response: lead-in 0xFF, 6-byte frame, 0xFF polls until an R1 byte
// (MSB=0) or the poll limit, trailing 0xFF, then chip select release.
// A watchdog aborts any byte transfer that never finishes.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_cmd_start     one-cycle request, accepted only while o_busy=0
//   i_cmd_index     command number, sampled on acceptance
//   i_cmd_arg       32-bit argument, sampled on acceptance
//   i_cmd_crc       CRC7, sampled on acceptance
//   o_busy          high from the cycle after acceptance until o_resp_valid
//   o_resp_valid    one-cycle pulse: command finished
//   o_resp_r1       R1 byte (or last byte received on timeout)
//   o_timeout       qualified by o_resp_valid: poll limit or watchdog expired
//   spi             byte handshake + chip select (master modport)
// ----------------------------------------------------------------------------
module sd_cmd_sequencer #(
   parameter int unsigned POLL_LIMIT  = 8,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_cmd_start,
   input  logic [5:0]                 i_cmd_index,
   input  logic [31:0]                i_cmd_arg,
   input  logic [6:0]                 i_cmd_crc,
   output logic                       o_busy,
   output logic                       o_resp_valid,
   output logic [7:0]                 o_resp_r1,
   output logic                       o_timeout,
   sd_cmd_sequencer_if.master         spi
);

   localparam int unsigned PW = 8;
   localparam int unsigned WW = 16;
   localparam logic [7:0]  FILL_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_CMD,
      S_POLL,
      S_TRAIL,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [5:0]      r_index;
   logic [31:0]     r_arg;
   logic [6:0]      r_crc;
   logic [2:0]      r_byte_idx;
   logic [PW-1:0]   r_poll_cnt;
   logic [WW-1:0]   r_wdog;
   logic            r_cs_n;
   logic            r_busy;
   logic            r_execute;
   logic [7:0]      r_out_word;
   logic            r_resp_valid;
   logic [7:0]      r_resp_r1;
   logic            r_timeout;
   logic [7:0]      w_next_cmd_byte;
   logic            w_poll_last;
   logic            w_wdog_expired;

   // Frame byte that follows the one currently in flight (bytes 1..5).
   always_comb begin
      w_next_cmd_byte = FILL_BYTE;
      case (r_byte_idx)
         3'd0:    w_next_cmd_byte = r_arg[31:24];
         3'd1:    w_next_cmd_byte = r_arg[23:16];
         3'd2:    w_next_cmd_byte = r_arg[15:8];
         3'd3:    w_next_cmd_byte = r_arg[7:0];
         3'd4:    w_next_cmd_byte = {r_crc, 1'b1};
         default: w_next_cmd_byte = FILL_BYTE;
      endcase
   end

   // The capture in progress is the POLL_LIMIT-th poll byte.
   assign w_poll_last    = (r_poll_cnt == PW'(POLL_LIMIT - 1));
   // Counter holds cycles elapsed since the execute cycle.
   assign w_wdog_expired = (r_wdog == WW'(WDOG_CYCLES - 1));

   // Sequencer FSM. Within a byte-sending state, r_execute=1 marks the ISSUE
   // cycle; every other cycle in that state is WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_index      <= '0;
         r_arg        <= '0;
         r_crc        <= '0;
         r_byte_idx   <= '0;
         r_poll_cnt   <= '0;
         r_wdog       <= '0;
         r_cs_n       <= 1'b1;
         r_busy       <= 1'b0;
         r_execute    <= 1'b0;
         r_out_word   <= FILL_BYTE;
         r_resp_valid <= 1'b0;
         r_resp_r1    <= FILL_BYTE;
         r_timeout    <= 1'b0;
      end else begin
         r_execute    <= 1'b0;
         r_resp_valid <= 1'b0;

         case (r_state)
            // DONE behaves like IDLE for acceptance, so back-to-back commands work.
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
               if (i_cmd_start) begin
                  r_index    <= i_cmd_index;
                  r_arg      <= i_cmd_arg;
                  r_crc      <= i_cmd_crc;
                  r_state    <= S_LEAD;
                  r_cs_n     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_execute  <= 1'b1;
                  r_out_word <= FILL_BYTE;
                  r_wdog     <= '0;
               end
            end

            S_LEAD, S_CMD, S_POLL, S_TRAIL: begin
               if (r_execute) begin
                  // ISSUE cycle: finished here is not a response to this byte
                  r_wdog <= r_wdog + WW'(1);
               end else if (spi.spi_finished) begin
                  r_wdog <= '0;
                  case (r_state)
                     S_LEAD: begin
                        r_state    <= S_CMD;
                        r_byte_idx <= '0;
                        r_execute  <= 1'b1;
                        r_out_word <= {2'b01, r_index};
                     end
                     S_CMD: begin
                        r_execute <= 1'b1;
                        if (r_byte_idx == 3'd5) begin
                           r_state    <= S_POLL;
                           r_poll_cnt <= '0;
                           r_out_word <= FILL_BYTE;
                        end else begin
                           r_byte_idx <= r_byte_idx + 3'd1;
                           r_out_word <= w_next_cmd_byte;
                        end
                     end
                     S_POLL: begin
                        r_resp_r1  <= spi.spi_in_word;
                        r_poll_cnt <= r_poll_cnt + PW'(1);
                        r_execute  <= 1'b1;
                        r_out_word <= FILL_BYTE;
                        r_timeout  <= 1'b0;
                        if (!spi.spi_in_word[7]) begin
                           r_state <= S_TRAIL;
                        end else if (w_poll_last) begin
                           r_state   <= S_TRAIL;
                           r_timeout <= 1'b1;
                        end
                     end
                     S_TRAIL: begin
                        r_state      <= S_DONE;
                        r_cs_n       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_resp_valid <= 1'b1;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end else if (w_wdog_expired) begin
                  // Stuck transfer: finish straight away, keep last R1 capture
                  r_state      <= S_DONE;
                  r_cs_n       <= 1'b1;
                  r_busy       <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_timeout    <= 1'b1;
                  r_wdog       <= '0;
               end else begin
                  r_wdog <= r_wdog + WW'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy           = r_busy;
   assign o_resp_valid     = r_resp_valid;
   assign o_resp_r1        = r_resp_r1;
   assign o_timeout        = r_timeout;
   assign spi.cs_n         = r_cs_n;
   assign spi.spi_execute  = r_execute;
   assign spi.spi_out_word = r_out_word;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sd_cmd_sequencer
// Bench for sd_cmd_sequencer: plays the spi_controller and SD card, issues
// directed and random commands, and scores each response against a model
// of the command/poll/watchdog rules.
// ----------------------------------------------------------------------------
module tb_sd_cmd_sequencer;

   localparam int unsigned POLL_LIMIT  = 8;
   localparam int unsigned WDOG_CYCLES = 1024;
   localparam int          WAIT_BOUND  = 3000;

   typedef struct packed {
      logic [7:0] r1;
      logic       to;
      logic       hang;
      logic [7:0] n;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [6:0]  cmd_crc;
   logic        busy;
   logic        resp_valid;
   logic [7:0]  resp_r1;
   logic        timeout;

   sd_cmd_sequencer_if spi_bus();

   sd_cmd_sequencer #(
      .POLL_LIMIT  (POLL_LIMIT),
      .WDOG_CYCLES (WDOG_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_cmd_start  (cmd_start),
      .i_cmd_index  (cmd_index),
      .i_cmd_arg    (cmd_arg),
      .i_cmd_crc    (cmd_crc),
      .o_busy       (busy),
      .o_resp_valid (resp_valid),
      .o_resp_r1    (resp_r1),
      .o_timeout    (timeout),
      .spi          (spi_bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   exp_t       exp_q[$];
   logic [7:0] exp_mosi_q[$];
   logic [7:0] mosi_log[$];

   // card / spi_controller model state
   bit         pending;
   bit         hung;
   int         dly;
   int         exec_idx;
   int         hang_idx;
   int         hang_cyc;
   logic [7:0] resp_cur;
   logic [7:0] poll_resp[16];
   logic [7:0] prev_r1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // One negedge of spi_controller + card behaviour.
   task automatic slave_step();
      spi_bus.spi_finished = 1'b0;
      spi_bus.spi_in_word  = 8'($urandom);
      if (pending && !hung) begin
         if (dly == 0) begin
            spi_bus.spi_finished = 1'b1;
            spi_bus.spi_in_word  = resp_cur;
            pending = 1'b0;
         end else begin
            dly--;
         end
      end else if (spi_bus.cs_n === 1'b1 && $urandom_range(0, 7) == 0) begin
         // stray / late finished while deselected must be ignored
         spi_bus.spi_finished = 1'b1;
      end
      if (spi_bus.spi_execute === 1'b1) begin
         check("exec_overlap", 32'(pending && !hung), 32'd0);
         check("cs_n_at_exec", 32'(spi_bus.cs_n), 32'd0);
         mosi_log.push_back(spi_bus.spi_out_word);
         pending = 1'b1;
         hung    = (exec_idx == hang_idx);
         dly     = $urandom_range(0, 3);
         if (hung) hang_cyc = cyc;
         if (exec_idx >= 7 && exec_idx < 23) resp_cur = poll_resp[exec_idx - 7];
         else                                resp_cur = 8'($urandom);
         exec_idx++;
      end
   endtask

   // Advance one cycle; occasionally pulse cmd_start while busy (must be ignored).
   task automatic tick();
      @(negedge clk);
      cmd_start = 1'b0;
      slave_step();
      if (busy === 1'b1 && $urandom_range(0, 7) == 0) begin
         cmd_start = 1'b1;
         cmd_index = 6'($urandom);
         cmd_arg   = $urandom;
         cmd_crc   = 7'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0) begin
         tick();
         n++;
         if (n > WAIT_BOUND) bound_fail("wait_idle");
      end
   endtask

   // Reference model: builds the expected frame and response, then issues.
   // hang_sel: -1 none, -2 random transfer, >=0 that transfer index never finishes.
   task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                            input int n_busy, input bit ff_only, input int hang_sel);
      logic [7:0] frame[$];
      int         npolls;
      int         h;
      int         n;
      logic [7:0] r1;
      logic       to;
      exp_t       e;
      for (int i = 0; i < 16; i++) begin
         if (i < n_busy)       poll_resp[i] = ff_only ? 8'hFF : (8'($urandom) | 8'h80);
         else if (i == n_busy) poll_resp[i] = 8'($urandom) & 8'h7F;
         else                  poll_resp[i] = 8'($urandom);
      end
      frame.push_back(8'hFF);
      frame.push_back({2'b01, idx});
      frame.push_back(arg[31:24]);
      frame.push_back(arg[23:16]);
      frame.push_back(arg[15:8]);
      frame.push_back(arg[7:0]);
      frame.push_back({crc, 1'b1});
      npolls = 0;
      for (int p = 0; p < int'(POLL_LIMIT); p++) begin
         npolls = p + 1;
         if (!poll_resp[p][7]) break;
      end
      r1 = poll_resp[npolls - 1];
      to = poll_resp[npolls - 1][7];
      for (int p = 0; p < npolls; p++) frame.push_back(8'hFF);
      frame.push_back(8'hFF);
      h = hang_sel;
      if (h == -2) h = $urandom_range(0, frame.size() - 1);
      if (h >= 0) begin
         to = 1'b1;
         n  = h + 1;
         if (h <= 7)                r1 = prev_r1;
         else if (h < 7 + npolls)   r1 = poll_resp[h - 8];
      end else begin
         n = frame.size();
      end
      for (int i = 0; i < n; i++) exp_mosi_q.push_back(frame[i]);
      e.r1   = r1;
      e.to   = to;
      e.hang = (h >= 0);
      e.n    = 8'(n);
      exp_q.push_back(e);
      prev_r1  = r1;
      exec_idx = 0;
      pending  = 1'b0;
      hung     = 1'b0;
      hang_idx = h;
      cmd_start = 1'b1;
      cmd_index = idx;
      cmd_arg   = arg;
      cmd_crc   = crc;
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                          input int n_busy, input bit ff_only, input int hang_sel, input int gap);
      tick();
      for (int g = 0; g < gap; g++) tick();
      wait_idle();
      issue_cmd(idx, arg, crc, n_busy, ff_only, hang_sel);
   endtask

   // Monitor: scores every resp_valid against the scoreboard.
   initial begin
      exp_t e;
      int   bad;
      int   bad_i;
      logic [7:0] eb;
      logic [7:0] ab;
      logic [7:0] bad_e;
      logic [7:0] bad_a;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: resp_valid with no command outstanding (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               check("resp_r1", 32'(resp_r1), 32'(e.r1));
               check("timeout", 32'(timeout), 32'(e.to));
               check("cs_n_at_done", 32'(spi_bus.cs_n), 32'd1);
               check("busy_at_done", 32'(busy), 32'd0);
               bad = 0;
               bad_i = 0;
               bad_e = 8'h00;
               bad_a = 8'h00;
               for (int i = 0; i < int'(e.n); i++) begin
                  eb = exp_mosi_q.pop_front();
                  ab = (i < mosi_log.size()) ? mosi_log[i] : 8'hXX;
                  if (ab !== eb && bad == 0) begin
                     bad   = 1;
                     bad_i = i;
                     bad_e = eb;
                     bad_a = ab;
                  end
               end
               checks++;
               if (mosi_log.size() != int'(e.n)) begin
                  errors++;
                  $display("FAIL mosi_frame: got %0d bytes expected %0d bytes", mosi_log.size(), e.n);
               end else if (bad != 0) begin
                  errors++;
                  $display("FAIL mosi_frame: byte %0d got %02h expected %02h", bad_i, bad_a, bad_e);
               end
               if (e.hang) check("wdog_latency", 32'(cyc - hang_cyc), 32'(WDOG_CYCLES));
            end
            mosi_log.delete();
         end
      end
   end

   initial begin
      int n;
      rst       = 1'b1;
      cmd_start = 1'b0;
      cmd_index = '0;
      cmd_arg   = '0;
      cmd_crc   = '0;
      spi_bus.spi_finished = 1'b0;
      spi_bus.spi_in_word  = 8'h00;
      pending  = 1'b0;
      hung     = 1'b0;
      dly      = 0;
      exec_idx = 0;
      hang_idx = -1;
      hang_cyc = 0;
      resp_cur = 8'hFF;
      prev_r1  = 8'hFF;
      repeat (3) @(negedge clk);
      check("rst_cs_n", 32'(spi_bus.cs_n), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_execute", 32'(spi_bus.spi_execute), 32'd0);
      check("rst_out_word", 32'(spi_bus.spi_out_word), 32'hFF);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_r1", 32'(resp_r1), 32'hFF);
      check("rst_timeout", 32'(timeout), 32'd0);
      rst = 1'b0;

      // CMD0: card answers FF then 01
      run_cmd(6'd0, 32'h0000_0000, 7'h4A, 1, 1'b1, -1, 2);
      // CMD8: R1 on the first poll byte, issued in the DONE cycle
      run_cmd(6'd8, 32'h0000_01AA, 7'h43, 0, 1'b1, -1, 0);
      // card never answers: poll limit
      run_cmd(6'd55, 32'h0000_0000, 7'h32, 16, 1'b1, -1, 0);
      // transfer 2 never finishes: watchdog
      run_cmd(6'd17, 32'h0000_0200, 7'h2A, 2, 1'b1, 2, 1);

      for (int k = 0; k < 40; k++) begin
         run_cmd(6'($urandom), $urandom, 7'($urandom),
                 $urandom_range(0, 10), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? -2 : -1,
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4));
      end

      // Reset while CMD byte 3 is in flight
      run_cmd(6'd24, 32'h1234_5678, 7'h11, 1, 1'b0, -1, 1);
      n = 0;
      while (exec_idx < 5) begin
         tick();
         n++;
         if (n > WAIT_BOUND) bound_fail("reach_cmd_byte3");
      end
      #2;
      rst       = 1'b1;
      cmd_start = 1'b0;
      #1;
      check("mid_rst_cs_n", 32'(spi_bus.cs_n), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_execute", 32'(spi_bus.spi_execute), 32'd0);
      check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      exp_q.delete();
      exp_mosi_q.delete();
      mosi_log.delete();
      pending  = 1'b0;
      hung     = 1'b0;
      hang_idx = -1;
      prev_r1  = 8'hFF;
      spi_bus.spi_finished = 1'b0;
      rst = 1'b0;

      run_cmd(6'd0, 32'h0000_0000, 7'h4A, 1, 1'b1, -1, 1);
      tick();
      wait_idle();
      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Sequences the byte-level spi_controller to issue one SD-card SPI-mode command frame and collect its R1 response. Per command:
- asserts chip select
- sends a 0xFF lead-in byte, then the 6-byte command frame
- polls with 0xFF until a valid R1 byte arrives or a poll limit expires
- sends a trailing 0xFF, then releases chip select

Sits between the SD init/read FSM (above) and spi_controller (below), which it drives through execute/out_word/in_word/finished.

Parameters:
POLL_LIMIT, 8, max poll bytes (NCR) sent while waiting for R1; range 1-255.
WDOG_CYCLES, 1024, clk cycles allowed between spi_execute pulse and spi_finished before abort; range 2-65535.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_start  in  1  one-cycle request; accepted only when busy=0
cmd_index  in  6  command number, sampled on accepted cmd_start
cmd_arg  in  32  argument, sampled on accepted cmd_start
cmd_crc  in  7  CRC7, sampled on accepted cmd_start
busy  out  1  high from the cycle after acceptance until the resp_valid cycle (exclusive)
resp_valid  out  1  one-cycle pulse: command finished
resp_r1  out  8  R1 byte, or last byte received on timeout; held until next resp_valid
timeout  out  1  qualified by resp_valid: poll limit or watchdog expired
cs_n  out  1  SD chip select, active low
spi_execute  out  1  one-cycle start pulse to spi_controller
spi_out_word  out  8  byte to transmit; stable from execute pulse until finished
spi_in_word  in  8  byte received by spi_controller, valid when spi_finished=1
spi_finished  in  1  one-cycle pulse from spi_controller: byte transfer complete

Behaviour:
- Reset (async, any state): state=IDLE, cs_n=1, busy=0, spi_execute=0, spi_out_word=0xFF, resp_valid=0, resp_r1=0xFF, timeout=0, all counters 0.
- States: IDLE, LEAD, CMD, POLL, TRAIL, DONE. Each byte-sending state has two sub-phases:
  - ISSUE: spi_execute=1 for exactly one cycle; spi_out_word set the same cycle.
  - WAIT: hold until spi_finished=1.
- Transfers never overlap: the next ISSUE is no earlier than the cycle after spi_finished.
- IDLE: cmd_start=1 → latch inputs; next cycle cs_n=0, busy=1, enter LEAD. cmd_start while busy=1 is ignored; latched fields are unchanged.
- LEAD: send 0xFF. On finished → CMD with byte index 0.
- CMD: byte index 0..5 sends, MSB first:
  - byte 0: {2'b01, cmd_index}
  - bytes 1-4: cmd_arg[31:24], [23:16], [15:8], [7:0]
  - byte 5: {cmd_crc, 1'b1}
  - After finished of byte 5 → POLL with poll count 0.
- POLL: send 0xFF. On finished, capture spi_in_word into resp_r1 and increment poll count.
  - in_word[7]=0 → TRAIL, timeout=0.
  - else if poll count = POLL_LIMIT → TRAIL, timeout=1.
  - else repeat POLL.
- TRAIL: send 0xFF. On finished → DONE.
- DONE (one cycle): cs_n=1, resp_valid=1, busy=0, state → IDLE. cmd_start asserted in this cycle is accepted.
- Watchdog:
  - Counter clears on every spi_execute and counts every WAIT cycle.
  - Reaching WDOG_CYCLES with no spi_finished, in any state → DONE directly with timeout=1, skipping TRAIL. resp_r1 keeps its last value.
  - A late spi_finished arriving in IDLE is ignored.
- spi_finished outside WAIT is ignored.
- Any byte with MSB=0 ends polling, including the first poll byte.
- resp_r1 and timeout change only in POLL capture or watchdog abort; both are valid at resp_valid.

Test Plan:
1. Start CMD0 (index 0, arg 0x00000000, crc 0x4A); model returns FF then 01 in POLL → MOSI bytes FF 40 00 00 00 00 95 FF FF FF; resp_valid with resp_r1=0x01, timeout=0; cs_n low for the whole sequence, high in the resp_valid cycle.
2. Start CMD8 (index 8, arg 0x000001AA, crc 0x43) → frame bytes 48 00 00 01 AA 87; model returns 01 on the first poll byte → exactly 1 poll byte, resp_r1=0x01.
3. Model returns 0xFF forever → exactly 8 poll bytes, then trailing FF; resp_valid with timeout=1, resp_r1=0xFF.
4. Model never pulses spi_finished after the 3rd execute → resp_valid with timeout=1 exactly 1024 cycles after that execute; cs_n=1; busy=0; no further execute.
5. Pulse cmd_start with different fields mid-CMD → ignored; transmitted frame matches the first command. Second cmd_start in the DONE cycle is accepted and its command runs.
6. Assert rst during CMD byte 3 → immediately cs_n=1, busy=0, spi_execute=0. After release, a new CMD0 runs cleanly as in scenario 1.
